// File: rtl/cpu_muldiv_unit.sv
// RV M-extension execute unit: multi-cycle multiply and iterative radix-2 divide,
// issued and retired through the same tag handshake as the ALU execute stage.
module cpu_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [2:0]           i_op,
  input  logic [XLEN-1:0]      i_rs1,
  input  logic [XLEN-1:0]      i_rs2,
  input  logic [4:0]           i_inst_rd,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [4:0]           o_inst_rd,
  output logic [XLEN-1:0]      o_rd,
  output logic                 o_stall
);

  localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic [XLEN-1:0]        a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]        quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic                   early_q, early_d;
  logic [4:0]             rd_q, rd_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;
  logic [4:0]             out_rd_q, out_rd_d;
  logic [XLEN-1:0]        out_res_q, out_res_d;

  logic                   div_zero, div_ovf;
  logic [XLEN-1:0]        early_res, fin_res;
  logic [XLEN:0]          trial, diff;

  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [2*XLEN-1:0] ea, eb, p;
    ea = (op == 3'd1 || op == 3'd2) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = (op == 3'd1) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ea * eb;
    return (op == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  // Quotient negated when operand signs differ; remainder follows the dividend sign.
  function automatic logic [XLEN-1:0] sign_fix(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] rem);
    logic signed [XLEN-1:0] q, r;
    q = quo;
    r = rem;
    if (!op[0]) begin
      if (a[XLEN-1] ^ b[XLEN-1]) q = -q;
      if (a[XLEN-1]) r = -r;
    end
    return op[1] ? r : q;
  endfunction

  assign o_stall   = (i_tag != out_tag_q);
  assign o_tag     = out_tag_q;
  assign o_inst_rd = out_rd_q;
  assign o_rd      = out_res_q;

  assign div_zero  = (i_rs2 == '0);
  assign div_ovf   = !i_op[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign early_res = div_zero ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : i_rs1);

  assign trial = {rem_q, quo_q[XLEN-1]};
  assign diff  = trial - {1'b0, dvs_q};

  assign fin_res = !op_q[2] ? mul_result(op_q, a_q, b_q) :
                   early_q  ? quo_q : sign_fix(op_q, a_q, b_q, quo_q, rem_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    early_d   = early_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    out_rd_d  = out_rd_q;
    out_res_d = out_res_q;
    case (state_q)
      S_IDLE: begin
        if (o_stall && !i_stall) begin
          op_d    = i_op;
          a_d     = i_rs1;
          b_d     = i_rs2;
          rd_d    = i_inst_rd;
          tag_d   = i_tag;
          early_d = 1'b0;
          if (!i_op[2]) begin
            if (MUL_STAGES == 1) begin
              state_d = S_FIN;
            end else begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_STAGES - 2);
            end
          end else if (div_zero || div_ovf) begin
            early_d = 1'b1;
            quo_d   = early_res;
            state_d = S_FIN;
          end else begin
            quo_d   = abs_val(i_rs1, !i_op[0]);
            dvs_d   = abs_val(i_rs2, !i_op[0]);
            rem_d   = '0;
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_FIN;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      // Restoring shift-subtract: one quotient bit per edge, MSB first.
      S_DIV: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIN;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIN: begin
        if (!i_stall) begin
          out_res_d = fin_res;
          out_rd_d  = rd_q;
          out_tag_d = tag_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      early_q   <= 1'b0;
      rd_q      <= '0;
      tag_q     <= '0;
      out_tag_q <= '0;
      out_rd_q  <= '0;
      out_res_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      early_q   <= early_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
      out_rd_q  <= out_rd_d;
      out_res_q <= out_res_d;
    end
  end

endmodule
